seg7_scan_gen: RTL and testbench

Parametrised multiplexing scan generator for multi-digit 7-segment displays; it replaces fixed 3-bit tap-select anode generation. A programmable prescaler advances a digit index that walks only the enabled digits. The block drives one-hot active-low anodes plus per-digit and per-frame strobes to the segment-data mux. It sits between the system clock domain and the board's anode pins.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_prescaler.sv | 47 ++++
 rtl/seg7_scan_gen.sv | 129 ++++++++++++
 tb/tb_seg7_scan_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared types, defaults and helpers for the 7-segment scan generator.
//   onehot_n(idx)                 : active-low one-hot anode vector (16 bits wide; callers slice)
//   next_enabled(idx, mask, n)    : next set mask bit strictly after idx, circular over n digits
package seg7_pkg;

    localparam int SEG7_MAX_DIGITS   = 16;
    localparam int SEG7_MAX_IDX_W    = 4;
    localparam int SEG7_DEF_DIGITS   = 8;
    localparam int SEG7_DEF_DIV_W    = 20;
    localparam int SEG7_DEF_BLANK    = 4;

    function automatic logic [SEG7_MAX_DIGITS-1:0] onehot_n(input logic [SEG7_MAX_IDX_W-1:0] idx);
        logic [SEG7_MAX_DIGITS-1:0] v;
        v = 16'd1 << idx;
        return ~v;
    endfunction

    // Returns idx itself when no other bit is set, so a lone enabled digit re-selects itself.
    function automatic logic [SEG7_MAX_IDX_W-1:0] next_enabled(
        input logic [SEG7_MAX_IDX_W-1:0]  idx,
        input logic [SEG7_MAX_DIGITS-1:0] mask,
        input int unsigned                n
    );
        logic [SEG7_MAX_IDX_W-1:0] res;
        logic                      found;
        int unsigned               j;
        res   = idx;
        found = 1'b0;
        for (int unsigned k = 1; k <= SEG7_MAX_DIGITS; k++) begin
            if (!found && (k <= n)) begin
                // idx < n and k <= n, so a single subtraction wraps the sum into range.
                j = int'(idx) + k;
                if (j >= n) begin
                    j = j - n;
                end else begin
                    j = j;
                end
                if (mask[j[SEG7_MAX_IDX_W-1:0]]) begin
                    res   = j[SEG7_MAX_IDX_W-1:0];
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// seg7_prescaler -- programmable step prescaler.
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : count enable; cnt holds while low
//   div_i    : terminal value; one step every div_i+1 enabled clocks
//   step_o   : high in the cycle whose closing edge performs a step
module seg7_prescaler #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             step_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             step_s;

    // Next count; >= lets a lowered div_i take effect immediately instead of wrapping.
    always_comb begin
        step_s = 1'b0;
        cnt_d  = cnt_q;
        if (en_i) begin
            if (cnt_q >= div_i) begin
                step_s = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_o = step_s;

endmodule

// File: rtl/seg7_scan_gen.sv
// seg7_scan_gen -- multiplexed scan generator for multi-digit 7-segment displays.
//   clk, rst      : clock, asynchronous active-high reset
//   en            : scan enable (low: hold state, anodes off, no strobes)
//   div_i         : prescaler terminal value (step every div_i+1 clocks)
//   digit_mask_i  : per-digit scan enable
//   idx_o         : current digit index for the segment-data mux
//   an_o          : active-low one-hot anodes
//   tick_o        : pulse on each index step; frame_o : pulse when the index wraps
// Optional feature: define SEG7_SCAN_BLANK_EN to blank anodes for BLANK_CYC clocks after each step.
module seg7_scan_gen
    import seg7_pkg::*;
#(
    parameter int  NUM_DIGITS = SEG7_DEF_DIGITS,
    parameter int  DIV_W      = SEG7_DEF_DIV_W,
    parameter int  BLANK_CYC  = SEG7_DEF_BLANK,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIV_W-1:0]      div_i,
    input  logic [NUM_DIGITS-1:0] digit_mask_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic                  tick_o,
    output logic                  frame_o
);

    logic                        step_s;
    logic                        blank_active_s;
    logic [SEG7_MAX_IDX_W-1:0]   nxt_s;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        tick_q, tick_d;
    logic                        frame_q, frame_d;
    logic [SEG7_MAX_DIGITS-1:0]  mask_ext_s;
    logic [SEG7_MAX_DIGITS-1:0]  an_full_s;

    seg7_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .div_i  (div_i),
        .step_o (step_s)
    );

    assign mask_ext_s = SEG7_MAX_DIGITS'(digit_mask_i);
    assign nxt_s      = next_enabled(SEG7_MAX_IDX_W'(idx_q), mask_ext_s, NUM_DIGITS);

    // Index step and strobes; an all-zero mask suppresses the step entirely.
    always_comb begin
        idx_d   = idx_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        if (step_s && (|digit_mask_i)) begin
            idx_d   = IDX_W'(nxt_s);
            tick_d  = 1'b1;
            frame_d = (IDX_W'(nxt_s) <= idx_q);
        end else begin
            idx_d   = idx_q;
        end
    end

`ifdef SEG7_SCAN_BLANK_EN
    logic [DIV_W-1:0] blank_q, blank_d;

    // Blank counter: reload on each step, count down otherwise, hold while disabled.
    always_comb begin
        blank_d = blank_q;
        if (!en) begin
            blank_d = blank_q;
        end else if (tick_d) begin
            blank_d = DIV_W'(BLANK_CYC);
        end else if (blank_q != '0) begin
            blank_d = blank_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            blank_d = blank_q;
        end
    end

    // Blank counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_active_s = (blank_d != '0);
`else
    logic unused_blank_s;
    assign unused_blank_s = (BLANK_CYC != 0);
    assign blank_active_s = 1'b0;
`endif

    assign an_full_s = onehot_n(SEG7_MAX_IDX_W'(idx_d));

    // Anodes follow the new index so they change on the same edge as the step.
    always_comb begin
        an_d = '1;
        if (en && digit_mask_i[idx_d] && !blank_active_s) begin
            an_d = an_full_s[NUM_DIGITS-1:0];
        end else begin
            an_d = '1;
        end
    end

    // Output and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            an_q    <= '1;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign idx_o   = idx_q;
    assign an_o    = an_q;
    assign tick_o  = tick_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_gen.sv
// tb_seg7_scan_gen -- randomized and directed stimulus against a behavioural scan model.
module tb_seg7_scan_gen;

    localparam int ND = 8;
    localparam int DW = 20;
`ifdef SEG7_SCAN_BLANK_EN
    localparam int M_BLANK = 4;
`else
    localparam int M_BLANK = 0;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] div;
    logic [ND-1:0] mask;
    logic [2:0]    idx_o;
    logic [ND-1:0] an_o;
    logic          tick_o;
    logic          frame_o;

    int n_cmp;
    int n_bad;

    // behavioural model state
    int            m_cnt;
    int            m_idx;
    int            m_blank;
    logic [ND-1:0] m_an;
    logic          m_tick;
    logic          m_frame;

    seg7_scan_gen #(.NUM_DIGITS(ND), .DIV_W(DW), .BLANK_CYC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div_i        (div),
        .digit_mask_i (mask),
        .idx_o        (idx_o),
        .an_o         (an_o),
        .tick_o       (tick_o),
        .frame_o      (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_idx   = 0;
        m_blank = 0;
        m_an    = '1;
        m_tick  = 1'b0;
        m_frame = 1'b0;
    endtask

    // One clock edge of the display scan, from the behavioural rules.
    task automatic model_edge();
        bit step;
        int nxt;
        bit found;
        if (rst) begin
            model_reset();
            return;
        end
        step = 0;
        if (en) begin
            if (m_cnt >= int'(div)) begin
                step  = 1;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_tick  = 1'b0;
        m_frame = 1'b0;
        if (step && mask != 0) begin
            found = 0;
            nxt   = m_idx;
            for (int k = 1; k <= ND; k++) begin
                if (!found && mask[(m_idx + k) % ND]) begin
                    nxt   = (m_idx + k) % ND;
                    found = 1;
                end
            end
            m_tick  = 1'b1;
            m_frame = (nxt <= m_idx);
            m_idx   = nxt;
            m_blank = M_BLANK;
        end else if (en && m_blank > 0) begin
            m_blank = m_blank - 1;
        end
        m_an = '1;
        if (en && mask[m_idx] && m_blank == 0) m_an[m_idx] = 1'b0;
    endtask

    task automatic check_all();
        check("idx",   32'(idx_o),   32'(m_idx));
        check("an",    32'(an_o),    32'(m_an));
        check("tick",  32'(tick_o),  32'(m_tick));
        check("frame", 32'(frame_o), 32'(m_frame));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        en    = 1'b0;
        div   = '0;
        mask  = '0;
        model_reset();
        @(negedge clk);
        check_all();
        check("an_rst_const", 32'(an_o), 32'hFF);
        rst = 1'b0;

        // full mask, step every 4 clocks
        en = 1'b1; div = DW'(3); mask = 8'hFF;
        run(40);

        // sparse mask, step every clock
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
        div = '0; mask = 8'b1010_0100;
        run(20);

        // empty mask, then a single digit
        mask = 8'h00; run(20);
        mask = 8'h01; run(20);

        // lowering div below the running count
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
        div = DW'(100); mask = 8'hFF;
        run(50);
        div = DW'(10);
        run(30);

        // asynchronous reset mid-scan at idx 5
        rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
        div = DW'(3); mask = 8'hFF;
        run(22);
        rst = 1'b1;
        #1;
        model_reset();
        check("idx_async_rst", 32'(idx_o), 32'd0);
        check("an_async_rst",  32'(an_o),  32'hFF);
        check("tick_async_rst", 32'(tick_o), 32'd0);
        run(2);
        rst = 1'b0;
        run(6);
        en = 1'b0; run(7);
        en = 1'b1; run(20);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mask = ND'($urandom);
            if ($urandom_range(0, 31) == 0) mask = ND'(1) << $urandom_range(0, ND - 1);
            if ($urandom_range(0, 31) == 0) div  = DW'($urandom_range(0, 6));
            en = ($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
